// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 and fault encodings shared by the data-memory load/store unit
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } err_e;
   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      return (funct3 == F3_B || funct3 == F3_BU) ? 3'd1
           : (funct3 == F3_H || funct3 == F3_HU) ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: byte-lane enables, store-data lane shift and load extension
module dmem_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wd,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld
);
   logic [2:0]  size;
   logic [31:0] sh;
   always_comb begin
      size  = access_size(funct3);
      be    = size == 3'd1 ? 4'b0001 << off : size == 3'd2 ? 4'b0011 << off : 4'b1111;
      wdata = wd << {off, 3'b000};
      sh    = rword >> {off, 3'b000};
      ld    = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}
            : funct3 == F3_BU ? {24'h0, sh[7:0]}
            : funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]}
            : funct3 == F3_HU ? {16'h0, sh[15:0]} : sh;
   end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data memory with RISC-V load/store front end and fault reporting
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES  = 256,
   parameter int INIT_PATTERN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        memwrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        rvalid,
   output logic [1:0]  err,
   output logic        err_sticky
);
   localparam int AW = $clog2(DEPTH_BYTES);
   logic [7:0]    mem [DEPTH_BYTES];
   logic [2:0]    size;
   logic [AW-1:0] base;
   err_e          code;
   logic          we;
   logic [3:0]    be;
   logic [31:0]   wdata, ld, rword;
   logic [31:0]   rd_d, rd_q;
   logic          rvalid_d, rvalid_q, sticky_d, sticky_q;
   err_e          err_d, err_q;
   always_comb begin
      size     = access_size(funct3);
      base     = addr[AW-1:0] & ~AW'(3);
      code     = (funct3 == 3'b011 || funct3[2:1] == 2'b11 || (memwrite && funct3[2])) ? ERR_ILLEGAL
               : ((size == 3'd2 && addr[0]) || (size == 3'd4 && addr[1:0] != 2'b00)) ? ERR_MISALIGN
               : ({1'b0, addr} + 33'(size) - 33'd1 >= 33'(DEPTH_BYTES)) ? ERR_RANGE : ERR_NONE;
      we       = req && memwrite && !rst && code == ERR_NONE;
      rword    = {mem[base | AW'(3)], mem[base | AW'(2)], mem[base | AW'(1)], mem[base]};
      rd_d     = req && !memwrite ? (code == ERR_NONE ? ld : 32'h0) : rd_q;
      rvalid_d = req && !memwrite;
      err_d    = req ? code : ERR_NONE;
      sticky_d = sticky_q || (req && code != ERR_NONE);
   end
   dmem_align u_align (
      .funct3(funct3),
      .off(addr[1:0]),
      .wd(wd),
      .rword(rword),
      .be(be),
      .wdata(wdata),
      .ld(ld)
   );
   // The array is never reset; each byte carries its power-up value as a declaration initialiser.
   for (genvar i = 0; i < DEPTH_BYTES; i++) begin : g_byte
      logic [7:0] byte_q = INIT_PATTERN != 0 ? 8'(i) : 8'h00;
      logic [7:0] byte_d;
      always_comb byte_d = we && be[i % 4] && base == AW'(i - i % 4) ? wdata[8 * (i % 4) +: 8] : byte_q;
      always_ff @(posedge clk) byte_q <= byte_d;
      assign mem[i] = byte_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q     <= 32'h0;
         rvalid_q <= 1'b0;
         err_q    <= ERR_NONE;
         sticky_q <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end
   assign rd         = rd_q;
   assign rvalid     = rvalid_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table, reset corner cases and randomized traffic against a byte-array model
module tb_dmem_lsu;
   logic        clk = 1'b0;
   logic        rst, req, memwrite;
   logic [2:0]  funct3;
   logic [31:0] addr, wd, rd;
   logic        rvalid, err_sticky;
   logic [1:0]  err;

   always #5 clk = ~clk;

   dmem_lsu #(.DEPTH_BYTES(256), .INIT_PATTERN(1)) dut (
      .clk(clk), .rst(rst), .req(req), .memwrite(memwrite), .funct3(funct3),
      .addr(addr), .wd(wd), .rd(rd), .rvalid(rvalid), .err(err), .err_sticky(err_sticky)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0]  m_mem [256];
   logic [31:0] m_rd;
   logic        m_rv, m_st;
   logic [1:0]  m_err;

   typedef struct packed {
      logic        r;
      logic        mw;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] rd;
      logic        rv;
      logic [1:0]  er;
      logic        st;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model(input logic r, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] w);
      int sz;
      logic [1:0] code;
      longint last;
      logic [31:0] v;
      if (!r) begin
         m_rv  = 1'b0;
         m_err = 2'd0;
         return;
      end
      sz   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      last = longint'({32'h0, a}) + sz - 1;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (mw && f3 >= 3'd4)) code = 2'd3;
      else if (a % sz != 0) code = 2'd1;
      else if (last >= 256) code = 2'd2;
      else code = 2'd0;
      m_err = code;
      m_st  = m_st | (code != 2'd0);
      m_rv  = !mw;
      if (mw) begin
         if (code == 2'd0)
            for (int k = 0; k < sz; k++) m_mem[int'(a) + k] = w[8 * k +: 8];
      end else if (code != 2'd0) begin
         m_rd = 32'h0;
      end else begin
         v = 32'h0;
         for (int k = 0; k < sz; k++) v = v | (32'(m_mem[int'(a) + k]) << (8 * k));
         if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
         if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         m_rd = v;
      end
   endtask

   task automatic step(input logic r, input logic mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w);
      @(negedge clk);
      req = r; memwrite = mw; funct3 = f3; addr = a; wd = w;
      model(r, mw, f3, a, w);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_rd = 32'h0; m_rv = 1'b0; m_err = 2'd0; m_st = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'(i);
      model_reset();
      rst = 1'b1; req = 1'b0; memwrite = 1'b0; funct3 = 3'd0; addr = 32'h0; wd = 32'h0;
      #12;
      chk("reset_rd", rd, 32'h0);
      chk("reset_rvalid", 32'(rvalid), 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_sticky", 32'(err_sticky), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h00,       32'h0,        32'h0302_0100, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd0, 32'h80,       32'h0,        32'hFFFF_FF80, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h80,       32'h0,        32'h0000_0080, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h82,       32'h0,        32'hFFFF_8382, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 3'd1, 32'h04,       32'hDACB_F567, 32'hFFFF_8382, 1'b0, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h04,       32'h0,        32'h0706_F567, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd5, 32'h06,       32'h0,        32'h0000_0706, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 3'd0, 32'h03,       32'h1234_56AB, 32'h0000_0706, 1'b0, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h00,       32'h0,        32'hAB02_0100, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd1, 32'hFE,       32'h0,        32'hFFFF_FFFE, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd5, 32'hFE,       32'h0,        32'h0000_FFFE, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd0, 32'hFF,       32'h0,        32'hFFFF_FFFF, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h02,       32'h0,        32'h0,         1'b1, 2'd1, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 3'd2, 32'h100,      32'hCA30_B91E, 32'h0,         1'b0, 2'd2, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd2, 32'hFC,       32'h0,        32'hFFFE_FDFC, 1'b1, 2'd0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd3, 32'h00,       32'h0,        32'h0,         1'b1, 2'd3, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 3'd4, 32'h10,       32'hFF,       32'h0,         1'b0, 2'd3, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h10,       32'h0,        32'h0000_0010, 1'b1, 2'd0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 3'd0, 32'h00,       32'h0,        32'h0000_0010, 1'b0, 2'd0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd1, 32'hFF,       32'h0,        32'h0,         1'b1, 2'd1, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd2, 32'hFE,       32'h0,        32'h0,         1'b1, 2'd1, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0,       32'h0,         1'b1, 2'd2, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 3'd5, 32'h00,       32'h0,        32'h0,         1'b0, 2'd3, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd0, 32'h100,      32'h0,        32'h0,         1'b1, 2'd2, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 3'd6, 32'h00,       32'h0,        32'h0,         1'b1, 2'd3, 1'b1});

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].mw, tbl[i].f3, tbl[i].a, tbl[i].w);
         chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
         chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].er));
         chk($sformatf("vec%0d_sticky", i), 32'(err_sticky), 32'(tbl[i].st));
      end

      step(1'b1, 1'b0, 3'd2, 32'h0C, 32'h0);
      chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
      chk("pre_rst_rd", rd, 32'h0F0E_0D0C);
      rst = 1'b1;
      req = 1'b0;
      #1;
      chk("async_rst_rd", rd, 32'h0);
      chk("async_rst_rvalid", 32'(rvalid), 32'h0);
      chk("async_rst_err", 32'(err), 32'h0);
      chk("async_rst_sticky", 32'(err_sticky), 32'h0);
      model_reset();
      req = 1'b1; memwrite = 1'b1; funct3 = 3'd2; addr = 32'h08; wd = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      chk("rst_hold_rvalid", 32'(rvalid), 32'h0);
      chk("rst_hold_err", 32'(err), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req = 1'b0;
      step(1'b1, 1'b0, 3'd2, 32'h08, 32'h0);
      chk("rst_dropped_store", rd, 32'h0B0A_0908);
      chk("rst_dropped_err", 32'(err), 32'h0);

      for (int n = 0; n < 600; n++) begin
         logic r, mw;
         logic [2:0] f3;
         logic [31:0] a;
         int sel;
         r   = $urandom_range(0, 9) != 0;
         mw  = $urandom_range(0, 1) == 1;
         f3  = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         a   = sel == 0 ? $urandom : sel == 1 ? 32'($urandom_range(248, 263)) : 32'($urandom_range(0, 255));
         if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
         step(r, mw, f3, a, $urandom);
         chk("rand_rd", rd, m_rd);
         chk("rand_rvalid", 32'(rvalid), 32'(m_rv));
         chk("rand_err", 32'(err), 32'(m_err));
         chk("rand_sticky", 32'(err_sticky), 32'(m_st));
      end

      for (int i = 0; i < 256; i += 4) begin
         step(1'b1, 1'b0, 3'd2, 32'(i), 32'h0);
         chk("final_dump", rd, m_rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised byte-addressed data memory with a RISC-V load/store front end. It sits in the MEM stage between the ALU address path and the writeback mux. It accepts one request per cycle and performs LB/LH/LW/LBU/LHU and SB/SH/SW with per-lane byte enables and sign/zero extension. Load data is registered with one cycle of latency. Misaligned, out-of-range and illegal-funct3 accesses are detected and reported, and a faulting access never modifies memory.

## Interface
- DEPTH_BYTES, 256: memory size in bytes; power of two, ≥4.
- INIT_PATTERN, 1: 1 means byte i initialised to i[7:0] at time zero; 0 means all bytes zero.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request valid this cycle.
- memwrite  in  1  1 = store, 0 = load; qualified by req.
- funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address.
- wd  in  32  store data; the low bytes are used for B/H.
- rd  out  32  load result, extended to 32 bits.
- rvalid  out  1  one-cycle pulse; rd and err are valid for a load.
- err  out  2  fault code for the previous request: 00 none, 01 misaligned, 10 out-of-range, 11 illegal funct3.
- err_sticky  out  1  set by any fault; cleared only by rst.

## Operation
- Request is accepted when req=1 at a rising clk edge with rst=0. There is no backpressure; one request per cycle.
- Fault check is combinational on the request, with priority illegal > misaligned > out-of-range:
  - Illegal: funct3 ∈ {011, 110, 111}, or memwrite=1 with funct3 ∈ {100, 101}.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0.
  - Out-of-range: addr + size − 1 ≥ DEPTH_BYTES, computed in 33 bits so no wrap. size is 1, 2 or 4.
- Store, no fault: write 1/2/4 bytes little-endian starting at addr. wd[7:0] goes to addr, wd[15:8] to addr+1, and so on. Other bytes are unchanged.
- Store, fault: no byte written. err is set and err_sticky sets.
- Load, no fault: read bytes little-endian.
  - B: sign-extend bit 7. BU: zero-extend.
  - H: sign-extend bit 15. HU: zero-extend.
  - W: 32 bits as stored.
- Load, fault: rd=0, rvalid=1, err=code.
- Store completion: rvalid stays 0. err for a store is still reported in the cycle after acceptance.
- Memory array is not reset. rst clears only the output/status registers.

## Timing
- Reset values: rd=0, rvalid=0, err=00, err_sticky=0.
- Load latency is 1: accepted at edge N, so rd, rvalid and err are valid after edge N and held until edge N+1.
- When there is no request at edge N+1, rvalid=0 and err=00, and rd holds its last value.
- Store takes effect at the accepting edge N.
- Load accepted at N+1 to the same bytes returns the new data (read-after-write, no hazard).
- Store and load cannot overlap in one cycle; there is one port.
- rst asserted mid-operation:
  - Outputs clear immediately.
  - A request sampled while rst=1 is dropped; a store is not written.
  - A pending rvalid is cancelled.
- Address bits above log2(DEPTH_BYTES) take part in the range check only.

## Structure
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - err codes ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL.
  - Function returning access size from funct3.
- Sub-module dmem_align, combinational:
  - Inputs funct3, addr[1:0], wd, raw 32-bit read word.
  - Outputs 4-bit byte enable, lane-shifted write data, and extended load value.
- dmem_lsu holds the byte array, fault check, output registers and err_sticky.

## Test plan
- Reset then LW at 0x00 (INIT_PATTERN=1): after one edge rd=0x03020100, rvalid=1, err=00.
- LB at 0x80: rd=0xFFFFFF80. LBU at 0x80: rd=0x00000080. LH at 0x82: rd=0xFFFF8382.
- SH at 0x04 with wd=0xDACBF567, then LW at 0x04 on the next cycle: rd=0x0706F567, with bytes 6–7 untouched.
- LW at 0x02: rd=0, rvalid=1, err=01, err_sticky=1. SW at 0x100 with wd=0xCA30B91E: err=10, and a following LW at 0xFC returns 0xFFFEFDFC (memory unchanged).
- funct3=011 load: err=11. SB with funct3=100: err=11, no write.
- Assert rst in the cycle after a load is accepted: rvalid, rd and err drop to 0 asynchronously. A SW at 0x08 held during rst leaves LW at 0x08 equal to 0x0B0A0908.
